// File: rtl/vector_writeback_unit_pkg.sv
// Shared encodings for the vector writeback stage: function-unit status,
// element-width codes and the writeback FSM states.
package vector_writeback_unit_pkg;

    // Function unit status
    localparam logic [1:0] VEC_ALU_NOP      = 2'd0;
    localparam logic [1:0] VEC_ALU_WORKING  = 2'd1;
    localparam logic [1:0] VEC_ALU_FINISHED = 2'd2;

    // Element width codes (ew = 8 << vsew)
    localparam logic [2:0] ONE_BYTE   = 3'd0;
    localparam logic [2:0] TWO_BYTE   = 3'd1;
    localparam logic [2:0] FOUR_BYTE  = 3'd2;
    localparam logic [2:0] EIGHT_BYTE = 3'd3;

    // Writeback FSM
    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_MERGE = 2'd1,
        WB_WRITE = 2'd2
    } wb_state_t;

endpackage

// File: rtl/vector_writeback_unit_merger.sv
// Combinational merge of a result vector into the old destination value.
// Active elements (i < length and unmasked) take the result; everything else,
// including tail and non-existent elements, keeps old_vd. For mask
// destinations only bit i of the register is written, from the LSB of
// result element i.
module vector_result_merger
    import vector_writeback_unit_pkg::*;
#(
    parameter int LEN              = 32,
    parameter int VECTOR_SIZE      = 8,
    parameter int ENTRY_INDEX_SIZE = 3
) (
    input  logic [VECTOR_SIZE*LEN-1:0] result,
    input  logic [VECTOR_SIZE*LEN-1:0] old_vd,
    input  logic [VECTOR_SIZE*LEN-1:0] mask,
    input  logic                       vm,
    input  logic [2:0]                 vsew,
    input  logic [ENTRY_INDEX_SIZE:0]  length,
    input  logic                       mask_dest,
    output logic [VECTOR_SIZE*LEN-1:0] merged
);

    localparam int TOTAL   = VECTOR_SIZE * LEN;
    localparam int NBYTES  = TOTAL / 8;
    localparam int IDXW    = $clog2(TOTAL);
    localparam int CW      = IDXW + 1;
    localparam int MAX_LEN = 1 << (ENTRY_INDEX_SIZE + 1);

    logic          sew_ok;
    logic [1:0]    sew;
    logic [CW-1:0] num_elems;
    logic [CW-1:0] len_x;

    // Only the four defined widths have elements; reserved codes write nothing
    assign sew_ok    = (vsew[2] == 1'b0);
    assign sew       = vsew[1:0];
    assign num_elems = CW'(NBYTES) >> sew;
    assign len_x     = CW'(length);

    logic [CW-1:0] idx;
    logic [CW-1:0] pos;

    // Per-element selection between result and old destination contents
    always_comb begin
        merged = old_vd;
        idx    = '0;
        pos    = '0;
        if (sew_ok) begin
            if (mask_dest) begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    idx = CW'(i);
                    pos = idx << ({1'b0, sew} + 3'd3);
                    if (idx < num_elems && idx < len_x && (vm || mask[idx[IDXW-1:0]]))
                        merged[idx[IDXW-1:0]] = result[pos[IDXW-1:0]];
                end
            end else begin
                // Byte granularity covers every element width; a byte belongs
                // to element (byte_index >> vsew)
                for (int b = 0; b < NBYTES; b++) begin
                    idx = CW'(b) >> sew;
                    if (idx < len_x && (vm || mask[idx[IDXW-1:0]]))
                        merged[b*8 +: 8] = result[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/vector_writeback_unit.sv
// Writeback stage behind the vector function unit: captures a finished
// result, merges it into the old destination in one cycle and issues a
// single full-register write over a valid/ready handshake.
module vector_writeback_unit
    import vector_writeback_unit_pkg::*;
#(
    parameter int LEN              = 32,
    parameter int VECTOR_SIZE      = 8,
    parameter int ENTRY_INDEX_SIZE = 3,
    parameter int REG_ADDR_WIDTH   = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 vector_alu_status,
    input  logic [VECTOR_SIZE*LEN-1:0] result,
    input  logic [VECTOR_SIZE*LEN-1:0] old_vd,
    input  logic [VECTOR_SIZE*LEN-1:0] mask,
    input  logic                       vm,
    input  logic [2:0]                 vsew,
    input  logic [ENTRY_INDEX_SIZE:0]  length,
    input  logic [REG_ADDR_WIDTH-1:0]  vd_addr,
    input  logic                       wb_en,
    input  logic                       mask_dest,
    input  logic                       rf_write_ready,
    output logic                       rf_write_valid,
    output logic [REG_ADDR_WIDTH-1:0]  rf_write_addr,
    output logic [VECTOR_SIZE*LEN-1:0] rf_write_data,
    output logic                       wb_busy,
    output logic                       wb_done,
    output logic                       overflow_err
);

    localparam int W = VECTOR_SIZE * LEN;

    wb_state_t state, state_next;

    logic [W-1:0]                cap_result, cap_old, cap_mask;
    logic                        cap_vm, cap_wb_en, cap_mask_dest;
    logic [2:0]                  cap_vsew;
    logic [ENTRY_INDEX_SIZE:0]   cap_len;
    logic [REG_ADDR_WIDTH-1:0]   cap_addr;
    logic [W-1:0]                merged;

    logic finished, capture, load_write, done_set, ovf_set;

    assign finished = (vector_alu_status == VEC_ALU_FINISHED);

    vector_result_merger #(
        .LEN              (LEN),
        .VECTOR_SIZE      (VECTOR_SIZE),
        .ENTRY_INDEX_SIZE (ENTRY_INDEX_SIZE)
    ) u_merger (
        .result    (cap_result),
        .old_vd    (cap_old),
        .mask      (cap_mask),
        .vm        (cap_vm),
        .vsew      (cap_vsew),
        .length    (cap_len),
        .mask_dest (cap_mask_dest),
        .merged    (merged)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= WB_IDLE;
        else      state <= state_next;
    end

    // Next state, capture/load strobes, done and overflow events
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        load_write = 1'b0;
        done_set   = 1'b0;
        ovf_set    = 1'b0;
        case (state)
            WB_IDLE: begin
                if (finished) begin
                    capture    = 1'b1;
                    state_next = WB_MERGE;
                end
            end
            WB_MERGE: begin
                load_write = 1'b1;
                if (finished) ovf_set = 1'b1;
                if (cap_wb_en && cap_len != '0) begin
                    state_next = WB_WRITE;
                end else begin
                    done_set   = 1'b1;
                    state_next = WB_IDLE;
                end
            end
            WB_WRITE: begin
                if (rf_write_ready) begin
                    done_set = 1'b1;
                    // A result finishing on the handshake edge is taken without a bubble
                    if (finished) begin
                        capture    = 1'b1;
                        state_next = WB_MERGE;
                    end else begin
                        state_next = WB_IDLE;
                    end
                end else if (finished) begin
                    ovf_set = 1'b1;
                end
            end
            default: state_next = WB_IDLE;
        endcase
    end

    // Capture registers for the finished instruction and its sideband
    always_ff @(posedge clk) begin
        if (!rst) begin
            cap_result    <= '0;
            cap_old       <= '0;
            cap_mask      <= '0;
            cap_vm        <= 1'b0;
            cap_vsew      <= '0;
            cap_len       <= '0;
            cap_addr      <= '0;
            cap_wb_en     <= 1'b0;
            cap_mask_dest <= 1'b0;
        end else if (capture) begin
            cap_result    <= result;
            cap_old       <= old_vd;
            cap_mask      <= mask;
            cap_vm        <= vm;
            cap_vsew      <= vsew;
            cap_len       <= length;
            cap_addr      <= vd_addr;
            cap_wb_en     <= wb_en;
            cap_mask_dest <= mask_dest;
        end
    end

    // Write request registers; held stable while the register file stalls
    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_write_data <= '0;
            rf_write_addr <= '0;
        end else if (load_write) begin
            rf_write_data <= merged;
            rf_write_addr <= cap_addr;
        end
    end

    // Retire pulse and sticky dropped-capture flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_done      <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            wb_done <= done_set;
            if (ovf_set) overflow_err <= 1'b1;
        end
    end

    // Valid is a pure function of state, so ready never reaches it combinationally
    assign rf_write_valid = (state == WB_WRITE);
    assign wb_busy        = (state != WB_IDLE);

endmodule

// File: tb/tb_vector_writeback_unit.sv
// Directed bench for vector_writeback_unit: merge patterns, stall, overflow,
// back-to-back capture, no-write retirement and mid-write reset.
module tb_vector_writeback_unit;
    import vector_writeback_unit_pkg::*;

    localparam int W = 256;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   vector_alu_status;
    logic [W-1:0] result, old_vd, mask;
    logic         vm, wb_en, mask_dest, rf_write_ready;
    logic [2:0]   vsew;
    logic [3:0]   length;
    logic [4:0]   vd_addr;
    logic         rf_write_valid, wb_busy, wb_done, overflow_err;
    logic [4:0]   rf_write_addr;
    logic [W-1:0] rf_write_data;

    int tests = 0;
    int fails = 0;

    vector_writeback_unit dut (
        .clk               (clk),
        .rst               (rst),
        .vector_alu_status (vector_alu_status),
        .result            (result),
        .old_vd            (old_vd),
        .mask              (mask),
        .vm                (vm),
        .vsew              (vsew),
        .length            (length),
        .vd_addr           (vd_addr),
        .wb_en             (wb_en),
        .mask_dest         (mask_dest),
        .rf_write_ready    (rf_write_ready),
        .rf_write_valid    (rf_write_valid),
        .rf_write_addr     (rf_write_addr),
        .rf_write_data     (rf_write_data),
        .wb_busy           (wb_busy),
        .wb_done           (wb_done),
        .overflow_err      (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction as FINISHED for exactly one sampling edge
    task automatic issue(input logic [W-1:0] r, input logic [W-1:0] o, input logic [W-1:0] m,
                         input logic v, input logic [2:0] s, input logic [3:0] l,
                         input logic [4:0] a, input logic e, input logic md);
        result = r; old_vd = o; mask = m; vm = v; vsew = s; length = l;
        vd_addr = a; wb_en = e; mask_dest = md;
        vector_alu_status = VEC_ALU_FINISHED;
        tick();
        vector_alu_status = VEC_ALU_NOP;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        tests++; if (rf_write_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", rf_write_valid); end
        tests++; if (rf_write_addr !== 5'd0) begin fails++; $display("FAIL reset_addr got %h exp 0", rf_write_addr); end
        tests++; if (rf_write_data !== '0) begin fails++; $display("FAIL reset_data got %h exp 0", rf_write_data); end
        tests++; if (wb_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", wb_busy); end
        tests++; if (wb_done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", wb_done); end
        tests++; if (overflow_err !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b exp 0", overflow_err); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_four_byte();
        logic [W-1:0] exp = {{3{32'h11111111}}, {5{32'hAAAAAAAA}}};
        rf_write_ready = 1'b1;
        issue({8{32'hAAAAAAAA}}, {8{32'h11111111}}, '0, 1'b1, FOUR_BYTE, 4'd5, 5'd7, 1'b1, 1'b0);
        // cycle N+1: merging
        tests++; if (wb_busy !== 1'b1) begin fails++; $display("FAIL fb_merge_busy got %b exp 1", wb_busy); end
        tests++; if (rf_write_valid !== 1'b0) begin fails++; $display("FAIL fb_merge_valid got %b exp 0", rf_write_valid); end
        tick(); // cycle N+2: write presented
        tests++; if (rf_write_valid !== 1'b1) begin fails++; $display("FAIL fb_valid got %b exp 1", rf_write_valid); end
        tests++; if (rf_write_addr !== 5'd7) begin fails++; $display("FAIL fb_addr got %h exp 7", rf_write_addr); end
        tests++; if (rf_write_data !== exp) begin fails++; $display("FAIL fb_data got %h exp %h", rf_write_data, exp); end
        tests++; if (wb_done !== 1'b0) begin fails++; $display("FAIL fb_done_early got %b exp 0", wb_done); end
        tick(); // cycle N+3
        tests++; if (wb_done !== 1'b1) begin fails++; $display("FAIL fb_done got %b exp 1", wb_done); end
        tests++; if (rf_write_valid !== 1'b0) begin fails++; $display("FAIL fb_valid_after got %b exp 0", rf_write_valid); end
        tests++; if (wb_busy !== 1'b0) begin fails++; $display("FAIL fb_busy_after got %b exp 0", wb_busy); end
        tick();
        tests++; if (wb_done !== 1'b0) begin fails++; $display("FAIL fb_done_pulse got %b exp 0", wb_done); end
    endtask

    task automatic test_masked();
        logic [W-1:0] exp;
        rf_write_ready = 1'b1;
        // bytes: mask bits beyond length are set but must not matter
        exp = {{6{32'h12345678}}, 64'h00FF00FF00FF00FF};
        issue({W{1'b1}}, {{6{32'h12345678}}, 64'h0}, 256'hFF55, 1'b0, ONE_BYTE, 4'd8, 5'd2, 1'b1, 1'b0);
        tick();
        tests++; if (rf_write_data !== exp) begin fails++; $display("FAIL byte_mask_data got %h exp %h", rf_write_data, exp); end
        tick(); tick();
        // halfwords: elements 1 and 2 active
        exp = {{13{16'h1234}}, 16'hBEEF, 16'hBEEF, 16'h1234};
        issue({16{16'hBEEF}}, {16{16'h1234}}, 256'h6, 1'b0, TWO_BYTE, 4'd3, 5'd9, 1'b1, 1'b0);
        tick();
        tests++; if (rf_write_data !== exp) begin fails++; $display("FAIL half_mask_data got %h exp %h", rf_write_data, exp); end
        tests++; if (rf_write_addr !== 5'd9) begin fails++; $display("FAIL half_mask_addr got %h exp 9", rf_write_addr); end
        tick(); tick();
        // mask destination: element 1 LSB is 0, element 3 is beyond length
        exp = ~256'h2;
        issue({64'h1, 64'h3, 64'h2, 64'h1}, {W{1'b1}}, '0, 1'b1, EIGHT_BYTE, 4'd3, 5'd4, 1'b1, 1'b1);
        tick();
        tests++; if (rf_write_data !== exp) begin fails++; $display("FAIL mask_dest_data got %h exp %h", rf_write_data, exp); end
        tick(); tick();
    endtask

    task automatic test_stall();
        logic [W-1:0] exp = {8{32'h5A5A5A5A}};
        rf_write_ready = 1'b0;
        issue(exp, '0, '0, 1'b1, FOUR_BYTE, 4'd8, 5'd3, 1'b1, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            tests++; if (rf_write_valid !== 1'b1) begin fails++; $display("FAIL stall_valid[%0d] got %b exp 1", k, rf_write_valid); end
            tests++; if (rf_write_addr !== 5'd3) begin fails++; $display("FAIL stall_addr[%0d] got %h exp 3", k, rf_write_addr); end
            tests++; if (rf_write_data !== exp) begin fails++; $display("FAIL stall_data[%0d] got %h exp %h", k, rf_write_data, exp); end
            tests++; if (wb_busy !== 1'b1) begin fails++; $display("FAIL stall_busy[%0d] got %b exp 1", k, wb_busy); end
            if (k == 1) begin
                result = {8{32'h0F0F0F0F}};
                vector_alu_status = VEC_ALU_FINISHED;
            end
            tick();
            vector_alu_status = VEC_ALU_NOP;
        end
        tests++; if (overflow_err !== 1'b1) begin fails++; $display("FAIL stall_ovf got %b exp 1", overflow_err); end
        tests++; if (rf_write_data !== exp) begin fails++; $display("FAIL stall_data_kept got %h exp %h", rf_write_data, exp); end
        rf_write_ready = 1'b1;
        tick();
        tests++; if (wb_done !== 1'b1) begin fails++; $display("FAIL stall_done got %b exp 1", wb_done); end
        tests++; if (wb_busy !== 1'b0) begin fails++; $display("FAIL stall_dropped_busy got %b exp 0", wb_busy); end
        tests++; if (overflow_err !== 1'b1) begin fails++; $display("FAIL stall_ovf_sticky got %b exp 1", overflow_err); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_b = {8{32'h3C3C3C3C}};
        rst = 1'b0; tick(); rst = 1'b1; tick();
        rf_write_ready = 1'b1;
        issue({8{32'h5A5A5A5A}}, '0, '0, 1'b1, FOUR_BYTE, 4'd8, 5'd1, 1'b1, 1'b0);
        tick(); // first write presented; second finishes on its handshake edge
        tests++; if (rf_write_addr !== 5'd1) begin fails++; $display("FAIL b2b_first_addr got %h exp 1", rf_write_addr); end
        issue(exp_b, '0, '0, 1'b1, FOUR_BYTE, 4'd8, 5'd2, 1'b1, 1'b0);
        tests++; if (wb_done !== 1'b1) begin fails++; $display("FAIL b2b_first_done got %b exp 1", wb_done); end
        tests++; if (wb_busy !== 1'b1) begin fails++; $display("FAIL b2b_merge_busy got %b exp 1", wb_busy); end
        tests++; if (rf_write_valid !== 1'b0) begin fails++; $display("FAIL b2b_merge_valid got %b exp 0", rf_write_valid); end
        tick();
        tests++; if (rf_write_valid !== 1'b1) begin fails++; $display("FAIL b2b_second_valid got %b exp 1", rf_write_valid); end
        tests++; if (rf_write_addr !== 5'd2) begin fails++; $display("FAIL b2b_second_addr got %h exp 2", rf_write_addr); end
        tests++; if (rf_write_data !== exp_b) begin fails++; $display("FAIL b2b_second_data got %h exp %h", rf_write_data, exp_b); end
        tests++; if (overflow_err !== 1'b0) begin fails++; $display("FAIL b2b_ovf got %b exp 0", overflow_err); end
        tick();
        tests++; if (wb_done !== 1'b1) begin fails++; $display("FAIL b2b_second_done got %b exp 1", wb_done); end
        tick();
    endtask

    task automatic test_no_write();
        rf_write_ready = 1'b1;
        // wb_en = 0
        issue({8{32'h77777777}}, '0, '0, 1'b1, FOUR_BYTE, 4'd8, 5'd5, 1'b0, 1'b0);
        tests++; if (rf_write_valid !== 1'b0) begin fails++; $display("FAIL nowr_merge_valid got %b exp 0", rf_write_valid); end
        tick();
        tests++; if (wb_done !== 1'b1) begin fails++; $display("FAIL nowr_done got %b exp 1", wb_done); end
        tests++; if (rf_write_valid !== 1'b0) begin fails++; $display("FAIL nowr_valid got %b exp 0", rf_write_valid); end
        tests++; if (wb_busy !== 1'b0) begin fails++; $display("FAIL nowr_busy got %b exp 0", wb_busy); end
        tick();
        // length = 0 with wb_en = 1
        issue({8{32'h77777777}}, '0, '0, 1'b1, FOUR_BYTE, 4'd0, 5'd5, 1'b1, 1'b0);
        tick();
        tests++; if (wb_done !== 1'b1) begin fails++; $display("FAIL len0_done got %b exp 1", wb_done); end
        tests++; if (rf_write_valid !== 1'b0) begin fails++; $display("FAIL len0_valid got %b exp 0", rf_write_valid); end
        tick();
    endtask

    task automatic test_reset_mid();
        rf_write_ready = 1'b0;
        issue({8{32'hDEADBEEF}}, '0, '0, 1'b1, FOUR_BYTE, 4'd8, 5'd6, 1'b1, 1'b0);
        tick();
        vector_alu_status = VEC_ALU_FINISHED;
        tick();
        vector_alu_status = VEC_ALU_NOP;
        tests++; if (overflow_err !== 1'b1) begin fails++; $display("FAIL rmid_ovf_set got %b exp 1", overflow_err); end
        tests++; if (rf_write_valid !== 1'b1) begin fails++; $display("FAIL rmid_valid_pre got %b exp 1", rf_write_valid); end
        rst = 1'b0;
        tick();
        tests++; if (rf_write_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid got %b exp 0", rf_write_valid); end
        tests++; if (wb_busy !== 1'b0) begin fails++; $display("FAIL rmid_busy got %b exp 0", wb_busy); end
        tests++; if (overflow_err !== 1'b0) begin fails++; $display("FAIL rmid_ovf got %b exp 0", overflow_err); end
        tests++; if (rf_write_addr !== 5'd0) begin fails++; $display("FAIL rmid_addr got %h exp 0", rf_write_addr); end
        tests++; if (rf_write_data !== '0) begin fails++; $display("FAIL rmid_data got %h exp 0", rf_write_data); end
        rst = 1'b1;
        rf_write_ready = 1'b1;
        tick();
        tests++; if (wb_busy !== 1'b0) begin fails++; $display("FAIL rmid_idle got %b exp 0", wb_busy); end
    endtask

    initial begin
        rst = 1'b0;
        vector_alu_status = VEC_ALU_NOP;
        result = '0; old_vd = '0; mask = '0;
        vm = 1'b1; vsew = FOUR_BYTE; length = '0; vd_addr = '0;
        wb_en = 1'b0; mask_dest = 1'b0; rf_write_ready = 1'b0;
        #1;
        test_reset();
        test_four_byte();
        test_masked();
        test_stall();
        test_back_to_back();
        test_no_write();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "timeout");
    end

endmodule
